// File: rtl/toggle_link_pkg.sv
// Shared definitions for the two-phase (toggle) handshake link.
// Holds the receiver FSM state encoding, the default parameter values used
// by both ends of the link, and a width helper for small down-counters.
package toggle_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DELAY = 2'd2,
    ST_ACK   = 2'd3
  } rx_state_e;

  localparam int DEF_DATA_W      = 7;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ACK_DELAY   = 2;
  localparam int DEF_CNT_W       = 8;

  // Bits needed to hold values 0..max_val; never less than one bit so a
  // zero-length delay still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/tt_um_nasser_hadi_toggle_rx_if.sv
// Toggle-link bundle plus the valid/ready consumer port of the receiver.
// Signals:
//   req_tgl   request level from the sender (asynchronous, one change = one request)
//   req_data  bundled data, stable from the toggle until ack_tgl answers
//   ack_tgl   acknowledge level returned to the sender
//   out_data  captured word toward the local consumer
//   out_valid out_data is valid
//   out_ready consumer accepts when out_valid && out_ready
// Modports: slave = receiver block, master = environment (sender + consumer).
interface tt_um_nasser_hadi_toggle_rx_if #(
  parameter int DATA_W = 7
);
  logic              req_tgl;
  logic [DATA_W-1:0] req_data;
  logic              ack_tgl;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  req_tgl, req_data, out_ready,
    output ack_tgl, out_data, out_valid
  );

  modport master (
    output req_tgl, req_data, out_ready,
    input  ack_tgl, out_data, out_valid
  );
endinterface

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser for a toggle level crossing into the clk domain.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset, clears every stage to 0
//   d_i  asynchronous level input
//   q_o  synchronised level (last stage)
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/tt_um_nasser_hadi_toggle_rx.sv
// Two-phase handshake responder. Synchronises the sender's request toggle,
// captures the bundled data word, offers it on a valid/ready port, and after
// acceptance plus ACK_DELAY idle cycles flips the acknowledge level.
// Ports:
//   clk       clock, all state on the rising edge
//   rst       synchronous active-high reset
//   link      toggle link + consumer port (slave modport)
//   busy      high whenever the FSM is not idle
//   xfer_cnt  completed transfers, modulo 2^CNT_W
//   err       sticky flag: request toggled again before being acknowledged
module tt_um_nasser_hadi_toggle_rx
  import toggle_link_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ACK_DELAY   = DEF_ACK_DELAY,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  tt_um_nasser_hadi_toggle_rx_if.slave  link,
  output logic                          busy,
  output logic [CNT_W-1:0]              xfer_cnt,
  output logic                          err
);
  localparam int DLY_W = cnt_width(ACK_DELAY);

  rx_state_e          state_q;
  logic               ack_q;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   xfer_cnt_q;
  logic [DLY_W-1:0]   dly_q;
  logic               err_q;
  logic               req_prev_q;
  logic               req_sync;
  logic               err_d;

  toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (link.req_tgl),
    .q_o (req_sync)
  );

  // Any movement of the synchronised request outside IDLE means the sender
  // re-toggled before seeing our ack.
  always_comb begin
    err_d = err_q;
    if ((state_q != ST_IDLE) && (req_sync != req_prev_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      xfer_cnt_q <= '0;
      dly_q      <= '0;
      err_q      <= 1'b0;
      req_prev_q <= 1'b0;
    end else begin
      req_prev_q <= req_sync;
      err_q      <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (req_sync != ack_q) begin
            data_q  <= link.req_data;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (valid_q && link.out_ready) begin
            valid_q <= 1'b0;
            dly_q   <= DLY_W'(ACK_DELAY);
            if (ACK_DELAY == 0) state_q <= ST_ACK;
            else                state_q <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          // The count reaches zero on the same edge that enters ACK, giving
          // exactly ACK_DELAY idle cycles between accept and the ack edge.
          dly_q <= dly_q - DLY_W'(1);
          if (dly_q == DLY_W'(1)) state_q <= ST_ACK;
        end
        ST_ACK: begin
          ack_q      <= ~ack_q;
          xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign link.ack_tgl   = ack_q;
  assign link.out_data  = data_q;
  assign link.out_valid = valid_q;
  assign busy           = (state_q != ST_IDLE);
  assign xfer_cnt       = xfer_cnt_q;
  assign err            = err_q;
endmodule

// File: tb/tb_tt_um_nasser_hadi_toggle_rx.sv
// Directed bench for the toggle-link receiver with default parameters.
module tb_tt_um_nasser_hadi_toggle_rx;
  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] xfer_cnt;
  logic       err;
  int         checks;
  int         errors;

  tt_um_nasser_hadi_toggle_rx_if #(.DATA_W(7)) bus ();

  tt_um_nasser_hadi_toggle_rx #(
    .DATA_W      (7),
    .SYNC_STAGES (2),
    .ACK_DELAY   (2),
    .CNT_W       (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .link     (bus),
    .busy     (busy),
    .xfer_cnt (xfer_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int lim, input string tag);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic wait_ack(input int lim, input string tag);
    int n;
    n = 0;
    while (bus.ack_tgl !== bus.req_tgl && n < lim) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, bus.ack_tgl}, {31'd0, bus.req_tgl});
  endtask

  initial begin
    logic [6:0] d;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.req_tgl   = 1'b0;
    bus.req_data  = 7'h00;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_ack",   {31'd0, bus.ack_tgl},   32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data",  {25'd0, bus.out_data},  32'd0);
    chk("rst_cnt",   {24'd0, xfer_cnt},      32'd0);
    chk("rst_err",   {31'd0, err},           32'd0);
    chk("rst_busy",  {31'd0, busy},          32'd0);
    rst = 1'b0;
    tick();

    // Single transfer: valid E2..E3, ack at E6
    bus.req_data  = 7'h5A;
    bus.out_ready = 1'b1;
    bus.req_tgl   = 1'b1;
    tick(); chk("s_valid_e0", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("s_valid_e1", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("s_valid_e2", {31'd0, bus.out_valid}, 32'd1);
    chk("s_data_e2", {25'd0, bus.out_data}, 32'h5A);
    chk("s_busy_e2", {31'd0, busy}, 32'd1);
    tick(); chk("s_valid_e3", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("s_ack_e4", {31'd0, bus.ack_tgl}, 32'd0);
    tick(); chk("s_ack_e5", {31'd0, bus.ack_tgl}, 32'd0);
    tick(); chk("s_ack_e6", {31'd0, bus.ack_tgl}, 32'd1);
    chk("s_cnt", {24'd0, xfer_cnt}, 32'd1);
    chk("s_err", {31'd0, err}, 32'd0);
    chk("s_busy_idle", {31'd0, busy}, 32'd0);

    // Back-pressure: 10 stalled cycles, then accept
    bus.out_ready = 1'b0;
    bus.req_data  = 7'h33;
    bus.req_tgl   = 1'b0;
    repeat (3) tick();
    chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_hold_data",  {25'd0, bus.out_data},  32'h33);
      chk("bp_hold_ack",   {31'd0, bus.ack_tgl},   32'd1);
    end
    bus.out_ready = 1'b1;
    tick(); chk("bp_accept", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_data_kept", {25'd0, bus.out_data}, 32'h33);
    tick(); chk("bp_ack_ea1", {31'd0, bus.ack_tgl}, 32'd1);
    tick(); chk("bp_ack_ea2", {31'd0, bus.ack_tgl}, 32'd1);
    tick(); chk("bp_ack_ea3", {31'd0, bus.ack_tgl}, 32'd0);
    chk("bp_cnt", {24'd0, xfer_cnt}, 32'd2);

    // Stream of 260 transfers from a clean reset, counter wraps
    rst = 1'b1;
    bus.req_tgl = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("st_cnt0", {24'd0, xfer_cnt}, 32'd0);
    for (int i = 0; i < 260; i++) begin
      d = 7'(i);
      bus.req_data = d;
      bus.req_tgl  = ~bus.req_tgl;
      wait_valid(20, "st_valid_timeout");
      chk("st_data", {25'd0, bus.out_data}, {25'd0, d});
      wait_ack(20, "st_ack_timeout");
      if (i == 254) chk("st_cnt_255", {24'd0, xfer_cnt}, 32'd255);
      if (i == 255) chk("st_cnt_wrap", {24'd0, xfer_cnt}, 32'd0);
    end
    chk("st_cnt_end", {24'd0, xfer_cnt}, 32'd4);
    chk("st_ack_end", {31'd0, bus.ack_tgl}, {31'd0, bus.req_tgl});
    chk("st_err", {31'd0, err}, 32'd0);

    // Violation: second toggle during HOLD
    bus.out_ready = 1'b0;
    bus.req_data  = 7'h11;
    bus.req_tgl   = ~bus.req_tgl;
    wait_valid(20, "v_valid1_timeout");
    chk("v_data1", {25'd0, bus.out_data}, 32'h11);
    bus.req_data = 7'h22;
    bus.req_tgl  = ~bus.req_tgl;
    repeat (3) tick();
    chk("v_err_set", {31'd0, err}, 32'd1);
    chk("v_hold_data", {25'd0, bus.out_data}, 32'h11);
    chk("v_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    tick(); chk("v_accept1", {31'd0, bus.out_valid}, 32'd0);
    wait_valid(20, "v_valid2_timeout");
    chk("v_data2", {25'd0, bus.out_data}, 32'h22);
    chk("v_cnt_mid", {24'd0, xfer_cnt}, 32'd5);
    wait_ack(20, "v_ack2_timeout");
    chk("v_cnt", {24'd0, xfer_cnt}, 32'd6);
    chk("v_err_sticky", {31'd0, err}, 32'd1);

    // Mid-operation reset with req_tgl held high
    bus.out_ready = 1'b0;
    bus.req_data  = 7'h4C;
    bus.req_tgl   = 1'b1;
    wait_valid(20, "mr_valid_timeout");
    rst = 1'b1;
    tick();
    chk("mr_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mr_ack",   {31'd0, bus.ack_tgl},   32'd0);
    chk("mr_busy",  {31'd0, busy},          32'd0);
    chk("mr_err",   {31'd0, err},           32'd0);
    chk("mr_cnt",   {24'd0, xfer_cnt},      32'd0);
    rst = 1'b0;
    tick(); chk("mr_valid_r1", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("mr_valid_r2", {31'd0, bus.out_valid}, 32'd0);
    tick(); chk("mr_valid_r3", {31'd0, bus.out_valid}, 32'd1);
    chk("mr_data", {25'd0, bus.out_data}, 32'h4C);
    bus.out_ready = 1'b1;
    wait_ack(20, "mr_ack_timeout");
    chk("mr_ack_done", {31'd0, bus.ack_tgl}, 32'd1);
    chk("mr_cnt_done", {24'd0, xfer_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
